lsu_ctrl: RTL and testbench

Load/store unit sitting between the execute/memory pipeline stage and the word-organised data memory. Accepts one RV32I load or store request per handshake, generates word addresses, byte strobes and lane-shifted write data for the memory, and assembles, shifts and sign/zero-extends the raw 32-bit read words into the architectural load result. Misaligned accesses that straddle a word boundary are split into two sequential word accesses by an internal state machine. The pipeline stalls while `req_ready` is low.

---
 rtl/lsu_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: byte strobes, lane shifting and load extension, with
// misaligned word-spanning accesses split into two sequential word accesses.
module lsu_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_func3,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_wsel,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam int unsigned DW = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            we_q;
  logic            err_q;
  logic [2:0]      func3_q;
  logic [XLEN-1:0] addr_q, wdata_q, lo_q, hi_q;

  logic            illegal;
  logic [3:0]      size_mask;
  logic [1:0]      off;
  logic [7:0]      lane_mask;
  logic [DW-1:0]   wshift;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] word_base;

  // Illegal funct3 decode on the incoming request
  always_comb begin
    if (req_we) illegal = (req_func3 > 3'd2);
    else        illegal = (req_func3 == 3'd3) || (req_func3[2:1] == 2'b11);
  end

  // Size, lane placement and load extraction from the latched request
  always_comb begin
    case (func3_q[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    off       = addr_q[1:0];
    lane_mask = {4'b0000, size_mask} << off;
    wshift    = DW'(wdata_q) << {off, 3'b000};
    raw       = XLEN'({hi_q, lo_q} >> {off, 3'b000});
    word_base = {addr_q[XLEN-1:2], 2'b00};
    case (func3_q)
      3'd0:    load_ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'd1:    load_ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'd4:    load_ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      3'd5:    load_ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: load_ext = raw;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    dmem_addr  = '0;
    dmem_we    = 1'b0;
    dmem_wsel  = 4'b0000;
    dmem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = illegal ? S_RESP : S_ACC0;
      end
      S_ACC0: begin
        dmem_addr  = word_base;
        dmem_we    = we_q;
        dmem_wsel  = we_q ? lane_mask[3:0] : 4'b0000;
        dmem_wdata = wshift[XLEN-1:0];
        state_d    = (|lane_mask[7:4]) ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        dmem_addr  = word_base + XLEN'(4);
        dmem_we    = we_q;
        dmem_wsel  = we_q ? lane_mask[7:4] : 4'b0000;
        dmem_wdata = wshift[DW-1:XLEN];
        state_d    = S_RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : load_ext;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Request latch and read-word capture; hi word cleared so non-spanning loads see 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            err_q   <= illegal;
            func3_q <= req_func3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            lo_q    <= '0;
            hi_q    <= '0;
          end
        end
        S_ACC0:  lo_q <= dmem_rdata;
        S_ACC1:  hi_q <= dmem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver pushes expected responses, a monitor
// pops and checks them whenever resp_valid is seen.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic [3:0]  dmem_wsel;

  lsu_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wsel(dmem_wsel),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  // Sparse word memory; unmapped addresses fall into scratch slot 5
  logic [31:0] mem [0:7];

  function automatic int idx(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 0;
      32'h0000_0104: return 1;
      32'h0000_0108: return 2;
      32'h0000_010C: return 3;
      32'hFFFF_FFFC: return 6;
      32'h0000_0000: return 7;
      default:       return 5;
    endcase
  endfunction

  assign dmem_rdata = mem[idx(dmem_addr)];

  always @(posedge clk) begin
    if (dmem_we) begin
      for (int b = 0; b < 4; b++)
        if (dmem_wsel[b]) mem[idx(dmem_addr)][8*b +: 8] = dmem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passes++;
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                       input int nacc,
                       input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_func3 = f3;
    exp_q.push_back('{exp_rd, exp_err, cyc + 1 + nacc});
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (nacc == 0) begin
      @(negedge clk);
      chk("idle_dmem_we", 32'(dmem_we), 32'd0);
      chk("idle_dmem_wsel", 32'(dmem_wsel), 32'd0);
      chk("idle_dmem_addr", dmem_addr, 32'd0);
    end else begin
      @(negedge clk);
      chk("acc0_addr", dmem_addr, a0);
      chk("acc0_wsel", 32'(dmem_wsel), 32'(s0));
      chk("acc0_wdata", dmem_wdata, d0);
      chk("acc0_we", 32'(dmem_we), 32'(we));
      if (nacc == 2) begin
        @(negedge clk);
        chk("acc1_addr", dmem_addr, a1);
        chk("acc1_wsel", 32'(dmem_wsel), 32'(s1));
        chk("acc1_wdata", dmem_wdata, d1);
        chk("acc1_we", 32'(dmem_we), 32'(we));
      end
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[3] = 32'h5555_5555;
    mem[6] = 32'h1234_5678;
    mem[7] = 32'h9ABC_DEF0;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_func3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    reset_n = 1'b1;

    // Aligned word store, then byte loads of its top byte
    issue(1, 32'h100, 32'hDEADBEEF, 3'd2, 32'h0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    issue(0, 32'h103, 32'h0, 3'd0, 32'hFFFFFFDE, 0, 1, 32'h100, 4'h0, 32'h0, 0, 0, 0);
    issue(0, 32'h103, 32'h0, 3'd4, 32'h000000DE, 0, 1, 32'h100, 4'h0, 32'h0, 0, 0, 0);
    // Upper halfword lane
    issue(1, 32'h102, 32'h0000A55A, 3'd1, 32'h0, 0, 1, 32'h100, 4'hC, 32'hA55A0000, 0, 0, 0);
    issue(0, 32'h102, 32'h0, 3'd1, 32'hFFFFA55A, 0, 1, 32'h100, 4'h0, 32'h0, 0, 0, 0);
    issue(0, 32'h102, 32'h0, 3'd5, 32'h0000A55A, 0, 1, 32'h100, 4'h0, 32'h0, 0, 0, 0);
    // Word-spanning store and load
    issue(1, 32'h102, 32'h11223344, 3'd2, 32'h0, 0, 2,
          32'h100, 4'hC, 32'h33440000, 32'h104, 4'h3, 32'h00001122);
    issue(0, 32'h102, 32'h0, 3'd2, 32'h11223344, 0, 2,
          32'h100, 4'h0, 32'h0, 32'h104, 4'h0, 32'h0);
    // Middle-lane halfword, word 0x100 now 3344BEEF
    issue(0, 32'h101, 32'h0, 3'd1, 32'h000044BE, 0, 1, 32'h100, 4'h0, 32'h0, 0, 0, 0);
    // Address wrap-around spanning halfword
    issue(0, 32'hFFFFFFFF, 32'h0, 3'd5, 32'h0000F012, 0, 2,
          32'hFFFFFFFC, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    issue(0, 32'hFFFFFFFF, 32'h0, 3'd0, 32'h00000012, 0, 1, 32'hFFFFFFFC, 4'h0, 32'h0, 0, 0, 0);
    // Illegal funct3
    issue(0, 32'h100, 32'h0, 3'd3, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 32'h100, 32'hCAFEF00D, 3'd4, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 32'h100, 32'h0, 3'd7, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset during ACC1 of a spanning store
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10A; req_wdata = 32'hAABBCCDD; req_func3 = 3'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_acc0_addr", dmem_addr, 32'h108);
    chk("rst_acc0_wdata", dmem_wdata, 32'hCCDD0000);
    @(negedge clk);
    chk("rst_acc1_addr", dmem_addr, 32'h10C);
    chk("rst_acc1_we", 32'(dmem_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_dmem_we", 32'(dmem_we), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    chk("midrst_word0", mem[2], 32'hCCDD0000);
    chk("midrst_word1", mem[3], 32'h55555555);
    issue(0, 32'h108, 32'h0, 3'd2, 32'hCCDD0000, 0, 1, 32'h108, 4'h0, 32'h0, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
